// File: rtl/jtcop_snd_pkg.sv
// Shared definitions for the main/sound CPU command mailbox.
//   INT_NMI / INT_IRQ : values for the mailbox INT_MODE parameter.
//   IDLE / ASSERT / GAP : state codes of the NMI pacing machine.
package jtcop_snd_pkg;

  localparam int unsigned INT_NMI = 0;
  localparam int unsigned INT_IRQ = 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StAssert = ASSERT,
    StGap    = GAP
  } nmi_state_e;

endpackage

// File: rtl/jtcop_edge.sv
// One-bit rising-edge detector.
//   clk  : system clock
//   rst  : synchronous active-high reset (clears the delayed copy)
//   din  : level input, may stay high for many cycles
//   rise : high for the single cycle where din=1 and its registered copy=0
module jtcop_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  always_comb begin
    rise = din & ~din_q;
  end

endmodule

// File: rtl/jtcop_snd_mbox.sv
// Command mailbox between the main CPU and the sound CPU.
// Main->sound commands go through a DEPTH-entry FIFO; sound->main replies use a
// single latch with a full flag. The sound CPU is interrupted either with one
// NMI pulse per queued command (paced by NMI_GAP) or with a level IRQ.
//   clk, rst              : clock, synchronous active-high reset
//   main_wr / main_din    : main CPU command write strobe and data
//   main_rd / main_dout   : main CPU reply read strobe and reply latch
//   main_clr              : clears the sticky overflow flag
//   reply_full            : reply written by sound CPU, not yet read by main
//   ovf                   : sticky command overflow flag
//   snd_rd / snd_dout     : sound CPU command read strobe and head command
//   snd_wr / snd_din      : sound CPU reply write strobe and data
//   snd_intn              : active-low interrupt to the sound CPU
//   count                 : FIFO occupancy, 0..DEPTH
module jtcop_snd_mbox
  import jtcop_snd_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INT_MODE  = INT_NMI,
  parameter int unsigned OVERWRITE = 0,
  parameter int unsigned NMI_GAP   = 16,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_wr,
  input  logic [DW-1:0] main_din,
  input  logic          main_rd,
  output logic [DW-1:0] main_dout,
  input  logic          main_clr,
  output logic          reply_full,
  output logic          ovf,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  input  logic          snd_wr,
  input  logic [DW-1:0] snd_din,
  output logic          snd_intn,
  output logic [AW:0]   count
);

  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q, reply_full_q;
  logic [DW-1:0] main_dout_q, snd_dout_q;

  logic wr_ev, rd_ev, pop_ev, rep_ev;
  logic full, empty, push_ok, pop_ok, ovf_set;

  // One event per strobe, however long the CPU holds it.
  jtcop_edge u_edge_main_wr (.clk(clk), .rst(rst), .din(main_wr), .rise(wr_ev));
  jtcop_edge u_edge_main_rd (.clk(clk), .rst(rst), .din(main_rd), .rise(rd_ev));
  jtcop_edge u_edge_snd_rd  (.clk(clk), .rst(rst), .din(snd_rd),  .rise(pop_ev));
  jtcop_edge u_edge_snd_wr  (.clk(clk), .rst(rst), .din(snd_wr),  .rise(rep_ev));

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    // A concurrent pop frees a slot, so a push on full is still accepted.
    push_ok = wr_ev & (~full | pop_ev);
    pop_ok  = pop_ev & ~empty;
    ovf_set = wr_ev & full & ~pop_ev;
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= main_din;
      end else if (ovf_set && (OVERWRITE != 0)) begin
        mem_q[wr_ptr_q - AW'(1)] <= main_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      snd_dout_q   <= '0;
      reply_full_q <= 1'b0;
      main_dout_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);

      // Overflow wins over a same-cycle clear so it is never lost.
      if (ovf_set)       ovf_q <= 1'b1;
      else if (main_clr) ovf_q <= 1'b0;

      // Registered head; on the pop edge the CPU still sees the old head.
      if (!empty) snd_dout_q <= mem_q[rd_ptr_q];

      // A reply write wins over a same-cycle read acknowledge.
      if (rep_ev) begin
        main_dout_q  <= snd_din;
        reply_full_q <= 1'b1;
      end else if (rd_ev) begin
        reply_full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    main_dout  = main_dout_q;
    reply_full = reply_full_q;
    ovf        = ovf_q;
    snd_dout   = snd_dout_q;
    count      = count_q;
  end

  if (INT_MODE == INT_IRQ) begin : g_irq
    logic intn_q;

    always_ff @(posedge clk) begin
      if (rst) intn_q <= 1'b1;
      else     intn_q <= empty;
    end

    always_comb begin
      snd_intn = intn_q;
    end
  end else begin : g_nmi
    localparam int unsigned GW = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;

    nmi_state_e    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
        gap_q   <= '0;
      end else begin
        state_q <= state_d;
        gap_q   <= gap_d;
      end
    end

    // Each command gets its own falling edge; the gap only starts once the
    // sound CPU has taken the current command, so later pushes just queue.
    always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      snd_intn = 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!empty) state_d = StAssert;
        end
        StAssert: begin
          snd_intn = 1'b0;
          if (pop_ev) begin
            state_d = StGap;
            gap_d   = GW'(NMI_GAP - 1);
          end
        end
        StGap: begin
          if (gap_q == '0) state_d = StIdle;
          else             gap_d   = gap_q - GW'(1);
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcop_snd_mbox.sv
module tb_jtcop_snd_mbox;

  logic       clk = 1'b0;
  logic       rst;
  logic       mwr, mrd, mclr, srd, swr;
  logic [7:0] mdin, sdin;

  logic [7:0] md0, md1, sd0, sd1;
  logic       rf0, rf1, ovf0, ovf1, in0, in1;
  logic [2:0] cnt0, cnt1;

  always #5 clk = ~clk;

  // NMI mode, drop on full
  jtcop_snd_mbox #(.DW(8), .DEPTH(4), .INT_MODE(0), .OVERWRITE(0), .NMI_GAP(16)) u_nmi (
    .clk(clk), .rst(rst), .main_wr(mwr), .main_din(mdin), .main_rd(mrd), .main_dout(md0),
    .main_clr(mclr), .reply_full(rf0), .ovf(ovf0), .snd_rd(srd), .snd_dout(sd0),
    .snd_wr(swr), .snd_din(sdin), .snd_intn(in0), .count(cnt0)
  );

  // IRQ mode, overwrite on full
  jtcop_snd_mbox #(.DW(8), .DEPTH(4), .INT_MODE(1), .OVERWRITE(1), .NMI_GAP(16)) u_irq (
    .clk(clk), .rst(rst), .main_wr(mwr), .main_din(mdin), .main_rd(mrd), .main_dout(md1),
    .main_clr(mclr), .reply_full(rf1), .ovf(ovf1), .snd_rd(srd), .snd_dout(sd1),
    .snd_wr(swr), .snd_din(sdin), .snd_intn(in1), .count(cnt1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int pop_cyc = 0;
  int falls  = 0;
  int fall_cyc = 0;
  logic in0_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    in0_prev <= in0;
    if (in0_prev === 1'b1 && in0 === 1'b0) begin
      falls    <= falls + 1;
      fall_cyc <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  task automatic do_reset();
    mwr = 0; mrd = 0; mclr = 0; srd = 0; swr = 0; mdin = 0; sdin = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic push(input logic [7:0] d, input int hold);
    mwr = 1; mdin = d;
    repeat (hold) @(negedge clk);
    mwr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop(output logic [7:0] v0, output logic [7:0] v1);
    srd = 1;
    pop_cyc = cyc + 1;
    v0 = sd0;
    v1 = sd1;
    repeat (2) @(negedge clk);
    srd = 0;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       sw;
    logic [7:0] sd;
    logic       mr;
    logic       c;
    logic [2:0] cnt;
    logic       o;
    logic       rf;
    logic [7:0] md;
  } vec_t;

  function automatic vec_t mk(bit w, int d, bit r, bit sw, int sd, bit mr, bit c,
                              int cnt, bit o, bit rf, int md);
    vec_t v;
    v.w = w; v.d = d[7:0]; v.r = r; v.sw = sw; v.sd = sd[7:0]; v.mr = mr; v.c = c;
    v.cnt = cnt[2:0]; v.o = o; v.rf = rf; v.md = md[7:0];
    return v;
  endfunction

  localparam int NV = 26;
  vec_t tbl [NV];

  // reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_ov0, m_ov1, m_rf, m_in1;
  logic [7:0] m_md, m_sd0, m_sd1;
  logic       p_wr, p_rd, p_srd, p_swr;

  logic [7:0] want_nmi [3];
  logic [7:0] v0, v1;
  int old, n, base, gap;
  bit ew, er, es, em, full0, full1, pok0, pok1, ovl0, ovl1;
  int pw, pr;

  initial begin
    //            w  d     r sw sd     mr c   cnt o rf md
    tbl[0]  = mk(0, 'h00, 0, 1, 'h7E, 0, 0,  0, 0, 1, 'h7E);
    tbl[1]  = mk(0, 'h00, 0, 1, 'h11, 0, 0,  0, 0, 1, 'h7E);
    tbl[2]  = mk(0, 'h00, 0, 0, 'h00, 0, 0,  0, 0, 1, 'h7E);
    for (int i = 3; i < 8; i++) tbl[i] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h7E);
    tbl[8]  = mk(0, 'h00, 0, 0, 'h00, 0, 0,  0, 0, 0, 'h7E);
    tbl[9]  = mk(0, 'h00, 0, 1, 'h3C, 1, 0,  0, 0, 1, 'h3C);
    tbl[10] = mk(0, 'h00, 0, 0, 'h00, 0, 0,  0, 0, 1, 'h3C);
    for (int i = 0; i < 4; i++) begin
      tbl[11 + 2 * i] = mk(1, i + 1, 0, 0, 0, 0, 0, i + 1, 0, 1, 'h3C);
      tbl[12 + 2 * i] = mk(0, 0,     0, 0, 0, 0, 0, i + 1, 0, 1, 'h3C);
    end
    tbl[19] = mk(1, 'h05, 0, 0, 'h00, 0, 0,  4, 1, 1, 'h3C);
    tbl[20] = mk(0, 'h00, 0, 0, 'h00, 0, 1,  4, 0, 1, 'h3C);
    tbl[21] = mk(1, 'h06, 0, 0, 'h00, 0, 1,  4, 1, 1, 'h3C);
    tbl[22] = mk(0, 'h00, 0, 0, 'h00, 0, 0,  4, 1, 1, 'h3C);
    tbl[23] = mk(0, 'h00, 1, 0, 'h00, 0, 0,  3, 1, 1, 'h3C);
    tbl[24] = mk(0, 'h00, 0, 0, 'h00, 0, 1,  3, 0, 1, 'h3C);
    tbl[25] = mk(0, 'h00, 0, 0, 'h00, 0, 0,  3, 0, 1, 'h3C);

    // reset state
    do_reset();
    check("rst_count0", cnt0, 0);
    check("rst_intn0", in0, 1);
    check("rst_intn1", in1, 1);
    check("rst_dout0", sd0, 0);
    check("rst_ovf0", ovf0, 0);
    check("rst_rfull0", rf0, 0);

    // reply latch / overflow / clear, one row per cycle
    for (int i = 0; i < NV; i++) begin
      mwr = tbl[i].w; mdin = tbl[i].d; srd = tbl[i].r; swr = tbl[i].sw;
      sdin = tbl[i].sd; mrd = tbl[i].mr; mclr = tbl[i].c;
      @(negedge clk);
      check($sformatf("tbl%0d_count0", i), cnt0, tbl[i].cnt);
      check($sformatf("tbl%0d_count1", i), cnt1, tbl[i].cnt);
      check($sformatf("tbl%0d_ovf0", i), ovf0, tbl[i].o);
      check($sformatf("tbl%0d_ovf1", i), ovf1, tbl[i].o);
      check($sformatf("tbl%0d_rfull0", i), rf0, tbl[i].rf);
      check($sformatf("tbl%0d_mdout0", i), md0, tbl[i].md);
      check($sformatf("tbl%0d_mdout1", i), md1, tbl[i].md);
    end

    // NMI pacing: one falling edge per command, gap measured from each pop
    do_reset();
    want_nmi[0] = 8'h11; want_nmi[1] = 8'h22; want_nmi[2] = 8'h33;
    base = falls;
    push(8'h11, 4); push(8'h22, 4); push(8'h33, 4);
    check("nmi_count", cnt0, 3);
    repeat (3) @(negedge clk);
    check("nmi_first_fall", falls - base, 1);
    check("nmi_low", in0, 0);
    for (int k = 0; k < 3; k++) begin
      pop(v0, v1);
      check($sformatf("nmi_pop%0d", k), v0, want_nmi[k]);
      check($sformatf("irq_pop%0d", k), v1, want_nmi[k]);
      if (k < 2) begin
        old = falls; n = 0;
        while (falls == old && n < 60) begin @(negedge clk); n++; end
        @(negedge clk);
        check($sformatf("nmi_refire%0d", k), falls - base, k + 2);
        gap = fall_cyc - pop_cyc;
        check($sformatf("nmi_gap%0d_ge16(gap=%0d)", k, gap), (gap >= 16), 1);
      end
    end
    repeat (40) @(negedge clk);
    check("nmi_total_falls", falls - base, 3);
    check("nmi_idle_high", in0, 1);
    check("nmi_empty", cnt0, 0);

    // overflow: drop (u_nmi) vs overwrite newest (u_irq)
    do_reset();
    for (int k = 0; k < 5; k++) push(8'hA0 + 8'(k), 1);
    check("ovfl_count0", cnt0, 4);
    check("ovfl_count1", cnt1, 4);
    check("ovfl_flag0", ovf0, 1);
    check("ovfl_flag1", ovf1, 1);
    for (int k = 0; k < 4; k++) begin
      pop(v0, v1);
      check($sformatf("drop_pop%0d", k), v0, 8'hA0 + 8'(k));
      check($sformatf("ovwr_pop%0d", k), v1, (k < 3) ? 8'hA0 + 8'(k) : 8'hA4);
    end

    // push+pop together on full, then on empty
    do_reset();
    for (int k = 0; k < 4; k++) push(8'hA0 + 8'(k), 1);
    mwr = 1; mdin = 8'h55; srd = 1;
    @(negedge clk);
    check("simul_full_count0", cnt0, 4);
    check("simul_full_count1", cnt1, 4);
    check("simul_full_ovf0", ovf0, 0);
    check("simul_full_ovf1", ovf1, 0);
    mwr = 0; srd = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pop(v0, v1);
      check($sformatf("simul_pop%0d_0", k), v0, (k < 3) ? 8'hA1 + 8'(k) : 8'h55);
      check($sformatf("simul_pop%0d_1", k), v1, (k < 3) ? 8'hA1 + 8'(k) : 8'h55);
    end
    check("simul_drained", cnt0, 0);
    mwr = 1; mdin = 8'h66; srd = 1;
    @(negedge clk);
    check("simul_empty_count0", cnt0, 1);
    check("simul_empty_count1", cnt1, 1);
    mwr = 0; srd = 0;
    repeat (2) @(negedge clk);
    pop(v0, v1);
    check("simul_empty_pop", v0, 8'h66);

    // IRQ level mode
    do_reset();
    push(8'hC1, 2); push(8'hC2, 2);
    check("irq_low", in1, 0);
    pop(v0, v1);
    repeat (3) @(negedge clk);
    check("irq_hold_after_pop1", in1, 0);
    srd = 1;
    @(negedge clk);
    check("irq_pop2_count", cnt1, 0);
    n = 0;
    while (in1 !== 1'b1 && n < 2) begin @(negedge clk); n++; end
    check("irq_release", in1, 1);
    srd = 0;
    @(negedge clk);

    // reset in the middle of operation
    do_reset();
    for (int k = 0; k < 5; k++) push(8'h01 + 8'(k), 1);
    pop(v0, v1);
    repeat (22) @(negedge clk);
    check("midrst_pre_count", cnt0, 3);
    check("midrst_pre_intn", in0, 0);
    check("midrst_pre_ovf", ovf0, 1);
    rst = 1;
    @(negedge clk);
    check("midrst_count0", cnt0, 0);
    check("midrst_count1", cnt1, 0);
    check("midrst_intn0", in0, 1);
    check("midrst_intn1", in1, 1);
    check("midrst_ovf0", ovf0, 0);
    check("midrst_ovf1", ovf1, 0);
    check("midrst_dout0", sd0, 0);
    check("midrst_dout1", sd1, 0);
    rst = 0;

    // randomized traffic against a queue-based model
    do_reset();
    q0.delete(); q1.delete();
    m_ov0 = 0; m_ov1 = 0; m_rf = 0; m_in1 = 1; m_md = 0; m_sd0 = 0; m_sd1 = 0;
    p_wr = 0; p_rd = 0; p_srd = 0; p_swr = 0;
    for (int i = 0; i < 800; i++) begin
      check("rnd_count0", cnt0, q0.size());
      check("rnd_count1", cnt1, q1.size());
      check("rnd_ovf0", ovf0, m_ov0);
      check("rnd_ovf1", ovf1, m_ov1);
      check("rnd_rfull0", rf0, m_rf);
      check("rnd_rfull1", rf1, m_rf);
      check("rnd_mdout0", md0, m_md);
      check("rnd_sdout0", sd0, m_sd0);
      check("rnd_sdout1", sd1, m_sd1);
      check("rnd_intn1", in1, m_in1);

      pw = ((i / 100) % 2 == 0) ? 45 : 20;
      pr = ((i / 100) % 2 == 0) ? 20 : 45;
      mwr  = ($urandom_range(0, 99) < pw);
      srd  = ($urandom_range(0, 99) < pr);
      swr  = ($urandom_range(0, 99) < 30);
      mrd  = ($urandom_range(0, 99) < 30);
      mclr = ($urandom_range(0, 99) < 8);
      mdin = 8'($urandom);
      sdin = 8'($urandom);

      ew = mwr && !p_wr; er = srd && !p_srd; es = swr && !p_swr; em = mrd && !p_mrd();
      m_in1 = (q1.size() == 0);
      if (q0.size() != 0) m_sd0 = q0[0];
      if (q1.size() != 0) m_sd1 = q1[0];
      full0 = (q0.size() == 4); full1 = (q1.size() == 4);
      pok0 = ew && (!full0 || er); pok1 = ew && (!full1 || er);
      ovl0 = ew && full0 && !er;   ovl1 = ew && full1 && !er;
      if (er && q0.size() != 0) void'(q0.pop_front());
      if (er && q1.size() != 0) void'(q1.pop_front());
      if (pok0) q0.push_back(mdin);
      if (pok1) q1.push_back(mdin);
      if (ovl1) q1[q1.size() - 1] = mdin;
      m_ov0 = ovl0 ? 1'b1 : (mclr ? 1'b0 : m_ov0);
      m_ov1 = ovl1 ? 1'b1 : (mclr ? 1'b0 : m_ov1);
      if (es) begin m_rf = 1; m_md = sdin; end
      else if (em) m_rf = 0;
      p_wr = mwr; p_rd = mrd; p_srd = srd; p_swr = swr;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic bit p_mrd();
    return p_rd;
  endfunction

endmodule
